// File: rtl/npu_power_csr_responder.sv
// CSR responder for the NPU power/DVFS window: energy accumulator with atomic
// 64-bit read, utilization moving average, DVFS thresholds and registered hints.
module npu_power_csr_responder #(
    parameter int ENERGY_INC_W     = 16,
    parameter int UTIL_MA_SHIFT    = 3,
    parameter int DEFAULT_HIGH_PCT = 80,
    parameter int DEFAULT_LOW_PCT  = 50
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    csr_valid,
    input  logic                    csr_write,
    input  logic [7:0]              csr_addr,
    input  logic [31:0]             csr_wdata,
    output logic [31:0]             csr_rdata,
    output logic                    csr_ready,
    input  logic                    energy_inc_valid,
    input  logic [ENERGY_INC_W-1:0] energy_inc,
    input  logic                    util_sample_valid,
    input  logic [10:0]             util_sample_milli,
    output logic [6:0]              util_high_thresh_pct,
    output logic [6:0]              util_low_thresh_pct,
    output logic                    dvfs_up_hint,
    output logic                    dvfs_down_hint
);

    localparam int ACC_W = 11 + UTIL_MA_SHIFT;

    localparam logic [7:0] ADDR_ENERGY_LO   = 8'h60;
    localparam logic [7:0] ADDR_ENERGY_HI   = 8'h64;
    localparam logic [7:0] ADDR_ENERGY_CTRL = 8'h68;
    localparam logic [7:0] ADDR_UTIL_INST   = 8'h90;
    localparam logic [7:0] ADDR_UTIL_MA     = 8'h94;
    localparam logic [7:0] ADDR_HIGH_THRESH = 8'hA0;
    localparam logic [7:0] ADDR_LOW_THRESH  = 8'hA4;

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t            state;
    logic              req_write;
    logic [7:0]        req_addr;
    logic [6:0]        req_wdata;
    logic [31:0]       rd_hold;
    logic [31:0]       rd_mux;
    logic              wdata_unused;

    logic [63:0]       energy_acc;
    logic [63:0]       energy_next;
    logic [64:0]       energy_sum;
    logic [63:0]       energy_inc_ext;
    logic [31:0]       energy_shadow;
    logic              commit;
    logic              energy_clear;

    logic [10:0]       util_inst;
    logic [10:0]       sample_clamped;
    logic [ACC_W-1:0]  util_acc;
    logic [10:0]       util_ma;
    logic [6:0]        wdata_clamped;
    logic [11:0]       high_x10;
    logic [11:0]       low_x10;
    logic              up_cond;
    logic              down_cond;

    assign wdata_unused   = ^csr_wdata[31:7];
    assign commit         = (state == ACK) && req_write;
    assign energy_clear   = commit && (req_addr == ADDR_ENERGY_CTRL) && req_wdata[0];
    assign energy_inc_ext = {{(64-ENERGY_INC_W){1'b0}}, energy_inc};
    assign energy_sum     = {1'b0, energy_acc} + {1'b0, energy_inc_ext};
    assign sample_clamped = (util_sample_milli > 11'd1000) ? 11'd1000 : util_sample_milli;
    assign util_ma        = util_acc[ACC_W-1:UTIL_MA_SHIFT];
    assign wdata_clamped  = (req_wdata > 7'd100) ? 7'd100 : req_wdata;
    assign high_x10       = {5'b0, util_high_thresh_pct} * 12'd10;
    assign low_x10        = {5'b0, util_low_thresh_pct} * 12'd10;
    assign up_cond        = {1'b0, util_ma} > high_x10;
    assign down_cond      = {1'b0, util_ma} < low_x10;

    // Read data is sampled from the live request at the IDLE->ACK edge.
    always_comb begin
        rd_mux = '0;
        case (csr_addr)
            ADDR_ENERGY_LO:   rd_mux = energy_acc[31:0];
            ADDR_ENERGY_HI:   rd_mux = energy_shadow;
            ADDR_UTIL_INST:   rd_mux = {21'b0, util_inst};
            ADDR_UTIL_MA:     rd_mux = {21'b0, util_ma};
            ADDR_HIGH_THRESH: rd_mux = {25'b0, util_high_thresh_pct};
            ADDR_LOW_THRESH:  rd_mux = {25'b0, util_low_thresh_pct};
            default:          rd_mux = '0;
        endcase
    end

    // A clear replaces the accumulator with this cycle's increment; otherwise saturate.
    always_comb begin
        energy_next = energy_acc;
        if (energy_clear) begin
            energy_next = energy_inc_valid ? energy_inc_ext : 64'd0;
        end else if (energy_inc_valid) begin
            energy_next = energy_sum[64] ? {64{1'b1}} : energy_sum[63:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            csr_ready <= 1'b0;
            csr_rdata <= '0;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            rd_hold   <= '0;
        end else begin
            csr_ready <= 1'b0;
            csr_rdata <= '0;
            case (state)
                IDLE: begin
                    if (csr_valid) begin
                        req_write <= csr_write;
                        req_addr  <= csr_addr;
                        req_wdata <= csr_wdata[6:0];
                        rd_hold   <= csr_write ? 32'd0 : rd_mux;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    csr_ready <= 1'b1;
                    csr_rdata <= rd_hold;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (!csr_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reading the low word snapshots the high word so the 64-bit pair is coherent.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            energy_acc           <= '0;
            energy_shadow        <= '0;
            util_inst            <= '0;
            util_acc             <= '0;
            util_high_thresh_pct <= 7'(DEFAULT_HIGH_PCT);
            util_low_thresh_pct  <= 7'(DEFAULT_LOW_PCT);
            dvfs_up_hint         <= 1'b0;
            dvfs_down_hint       <= 1'b0;
        end else begin
            energy_acc <= energy_next;
            if (state == IDLE && csr_valid && !csr_write && csr_addr == ADDR_ENERGY_LO)
                energy_shadow <= energy_acc[63:32];
            if (util_sample_valid) begin
                util_inst <= sample_clamped;
                util_acc  <= util_acc - (util_acc >> UTIL_MA_SHIFT)
                             + {{UTIL_MA_SHIFT{1'b0}}, sample_clamped};
            end
            if (commit && req_addr == ADDR_HIGH_THRESH) util_high_thresh_pct <= wdata_clamped;
            if (commit && req_addr == ADDR_LOW_THRESH)  util_low_thresh_pct  <= wdata_clamped;
            dvfs_up_hint   <= up_cond;
            dvfs_down_hint <= down_cond && !up_cond;
        end
    end

endmodule
